// File: rtl/gemm_result_reader_if.sv
// gemm_result_reader_if: result stream valid/ready bundle.
// master drives data/valid/last, slave drives ready.
interface gemm_result_reader_if #(
  parameter int OutDataWidth = 32
);
  logic [OutDataWidth-1:0] m_data_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic                    m_last_o;

  modport master (
    output m_data_o,
    output m_valid_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o,
    input  m_valid_o,
    input  m_last_o,
    output m_ready_i
  );
endinterface

// File: rtl/gemm_result_reader.sv
// gemm_result_reader: drains GeMM C SRAM, one word per tile,
// and streams its meshRow*meshCol elements LSB first.
// Ports: clk_i/rst_ni; start_i, M_size_i, N_size_i (latched);
// sram_c_addr_o/re_o/rdata_i (1-cycle read latency);
// m_if (data/valid/ready/last stream); busy_o, done_o.
module gemm_result_reader #(
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int meshRow       = 2,
  parameter int meshCol       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_re_o,
  input  logic [meshRow*meshCol*OutDataWidth-1:0] sram_c_rdata_i,
  gemm_result_reader_if.master     m_if,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int E  = meshRow * meshCol;
  localparam int EW = (E > 1) ? $clog2(E) : 1;
  localparam int TW = 2 * SizeAddrWidth;
  localparam int WW = E * OutDataWidth;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [TW-1:0]   b_q, b_d;
  logic [EW-1:0]   e_q, e_d;
  logic [WW-1:0]   buf_q, buf_d;

  logic [TW-1:0]   prod;
  logic            blk_last;
  logic            ele_last;
  logic            hs;
  logic [OutDataWidth-1:0] elem;

  assign prod = {{SizeAddrWidth{1'b0}}, M_size_i}
              * {{SizeAddrWidth{1'b0}}, N_size_i};

  // t_q is nonzero whenever STREAM is reachable
  assign blk_last = (b_q == t_q - TW'(1));
  assign ele_last = (e_q == EW'(E - 1));
  assign hs = m_if.m_valid_o && m_if.m_ready_i;

  always_comb begin
    elem = '0;
    for (int i = 0; i < E; i++) begin
      if (e_q == EW'(i)) begin
        elem = buf_q[i*OutDataWidth +: OutDataWidth];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    b_d           = b_q;
    e_d           = e_q;
    buf_d         = buf_q;
    sram_c_re_o   = 1'b0;
    sram_c_addr_o = '0;
    m_if.m_valid_o = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          t_d = prod;
          b_d = '0;
          e_d = '0;
          state_d = (prod == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        sram_c_re_o   = 1'b1;
        sram_c_addr_o = AddrWidth'(b_q);
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        buf_d   = sram_c_rdata_i;
        e_d     = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        m_if.m_valid_o = 1'b1;
        if (hs) begin
          if (ele_last) begin
            e_d = '0;
            if (blk_last) begin
              state_d = S_DONE;
            end else begin
              b_d     = b_q + TW'(1);
              state_d = S_READ;
            end
          end else begin
            e_d = e_q + EW'(1);
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_if.m_data_o = elem;
  assign m_if.m_last_o = (state_q == S_STREAM)
                       && blk_last && ele_last;
  assign busy_o = (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      b_q     <= '0;
      e_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      b_q     <= b_d;
      e_q     <= e_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: doc/gemm_result_reader.md
# gemm_result_reader

Drains the GeMM output SRAM (matrix C) after a GeMM run completes and streams the results out element by element over a valid/ready interface. C is stored block-row-major: one SRAM word per `[M_block][N_block]` output tile, holding `meshRow*meshCol` accumulators. This block is the read side of that store. It sits between the C SRAM read port and the host/DMA result stream.

## Interface
Parameters:
- `OutDataWidth`, default 32: width of one result element.
- `AddrWidth`, default 16: SRAM C address width.
- `SizeAddrWidth`, default 8: width of the block-count inputs.
- `meshRow`, default 2: rows per output tile.
- `meshCol`, default 2: columns per output tile. Elements per word: E = `meshRow*meshCol`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `start_i`, input, 1: start drain. Sampled only in IDLE.
- `M_size_i`, input, `SizeAddrWidth`: number of M blocks. Latched at start.
- `N_size_i`, input, `SizeAddrWidth`: number of N blocks. Latched at start.
- `sram_c_addr_o`, output, `AddrWidth`: C read address.
- `sram_c_re_o`, output, 1: C read enable. Read latency is 1 cycle.
- `sram_c_rdata_i`, input, `E*OutDataWidth`: C read data, signed elements.
- `m_data_o`, output, `OutDataWidth`: stream element.
- `m_valid_o`, output, 1: stream valid.
- `m_ready_i`, input, 1: stream ready.
- `m_last_o`, output, 1: final element of the final block. Qualified by `m_valid_o`.
- `busy_o`, output, 1: high when state ≠ IDLE.
- `done_o`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, READ, WAIT, STREAM, DONE.
- **IDLE**
  - On `start_i`: latch sizes, compute T = M*N (width 2*`SizeAddrWidth`), clear block index b and element index e.
  - If T = 0, go to DONE. Otherwise go to READ.
- **READ**
  - `sram_c_re_o`=1, `sram_c_addr_o`=b truncated to `AddrWidth`. This equals m*N+n for row-major traversal.
  - Always go to WAIT.
- **WAIT**
  - Register `sram_c_rdata_i` into the word buffer, set e=0, go to STREAM.
- **STREAM**
  - `m_valid_o`=1. `m_data_o` = buffer[e*`OutDataWidth` +: `OutDataWidth`], so element e = r*meshCol+c, LSB first.
  - On `m_valid_o && m_ready_i`, e increments.
  - When element E-1 is accepted: if b = T-1, go to DONE; else b++ and go to READ.
- **DONE**
  - `done_o`=1 for exactly one cycle, then go to IDLE.
- `m_last_o` = STREAM && b = T-1 && e = E-1.
- `start_i` outside IDLE is ignored. The latched sizes hold for the whole run, so input changes mid-run have no effect.
- Stream rules:
  - While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` and `m_last_o` hold stable.
  - `m_valid_o` never drops before the handshake.
  - `m_ready_i` outside STREAM is ignored.
- No read is issued while buffer data is still pending. At most one SRAM read is outstanding.

## Timing
- All outputs reset to 0: addr, re, data, valid, last, busy, done. State resets to IDLE.
- An asynchronous reset mid-run aborts the run immediately. No `done_o` is produced, and the next start restarts from block 0.
- Start latency: with `start_i` high in cycle 0 (IDLE), READ occurs in cycle 1, WAIT in cycle 2, and first `m_valid_o` in cycle 3.
- With `m_ready_i` held at 1:
  - Each block takes 2+E cycles.
  - A full drain takes T*(2+E) cycles plus 1 DONE cycle.
  - `done_o` is asserted in cycle 1+T*(2+E).
- T = 0: `done_o` is high in cycle 1, with no `sram_c_re_o` and no `m_valid_o`.
- Back-to-back runs: `start_i` asserted in the DONE cycle is ignored. It is accepted in the following IDLE cycle.
- Address wrap: if T > 2^`AddrWidth`, the address truncates modulo 2^`AddrWidth`. No error is flagged.

## Test plan
- Basic drain, M=2, N=2, E=4, `m_ready_i`=1:
  - Stimulus: word k holds elements {4k+3, 4k+2, 4k+1, 4k} (element 0 in the LSBs).
  - Required: 16 elements in order 0..15; `m_last_o` only on element 15; addresses 0, 1, 2, 3 with `re` in cycles 1, 7, 13, 19; `done_o` in cycle 25.
- Backpressure: same setup, `m_ready_i` toggling 1,0,0,1,...
  - Required: identical element sequence; data stable during every stall; no duplicate or dropped elements.
- Zero size: M=0, N=5.
  - Required: `done_o` in cycle 1; `re` never asserted; `m_valid_o` never asserted.
- Signed data: word containing elements {−1, 0x7FFFFFFF, 0x80000000, 5}.
  - Required: emitted bit-exact in element-index order.
- Ignored start and live sizes: pulse `start_i` and change `M_size_i`/`N_size_i` during STREAM.
  - Required: no restart; the drain still covers the originally latched T.
- Reset mid-run: assert `rst_ni` low during block 1 of a 2×2 run.
  - Required: all outputs 0 at once and no `done_o`.
  - A new start with M=1, N=1 reads address 0 and emits 4 elements.
